// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared sizing constants and word/address types for the MIPS data memory.
//   DM_ADDR_WIDTH : word-address width (depth = 2**DM_ADDR_WIDTH)
//   DM_DATA_WIDTH : word width in bits
//   DM_DEPTH      : number of words
// -----------------------------------------------------------------------------
package data_memory_pkg;

    localparam int DM_ADDR_WIDTH = 10;
    localparam int DM_DATA_WIDTH = 32;
    localparam int DM_DEPTH      = 1 << DM_ADDR_WIDTH;

    typedef logic [DM_ADDR_WIDTH-1:0] dm_addr_t;
    typedef logic [DM_DATA_WIDTH-1:0] dm_word_t;

endpackage : data_memory_pkg

// File: rtl/data_memory_array.sv
// -----------------------------------------------------------------------------
// data_memory_array
// Storage array of 2**ADDR_WIDTH words with a single-edge clear, one
// synchronous full-word write port and one asynchronous read port.
// Ports:
//   clk        : rising-edge clock
//   reset_i    : synchronous active-high clear of every word (beats writes)
//   wr_en_i    : write enable, sampled on rising clk
//   addr_i     : word index shared by the write and read ports
//   wr_data_i  : store data
//   rd_data_o  : mem[addr_i], combinational, contents before the next edge
// -----------------------------------------------------------------------------
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Declaration initialiser gives the power-up contents of zero, so
    // locations never written (and never reset) read back as 0.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    // NOTE: the whole array must clear in one edge, so it is built from
    // resettable flops rather than an inferred RAM macro; the loop below is a
    // per-word reset, which block RAMs cannot provide.
    // NOTE: state is updated with non-blocking assignments so every reader in
    // this cycle sees the pre-edge value regardless of process order.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    // No forwarding: a read to the address being written shows the old word
    // until the edge commits the new one.
    assign rd_data_o = mem_q[addr_i];

endmodule : data_memory_array

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-addressed data memory for the single-cycle MIPS datapath. Sits between
// the ALU result (address) and the register-file write-back mux (read data).
// Ports:
//   clk        : sole clock, rising edge
//   reset      : synchronous active-high, clears every word
//   memwrite   : store enable, full-word write on rising clk
//   memread    : load enable; read_data is forced to 0 when low
//   address    : word index (not a byte address)
//   write_data : store data
//   read_data  : load data
// Configuration macro:
//   DATA_MEMORY_READ_REG_EN : when defined, read_data is registered (one cycle
//                             of latency, cleared by reset); otherwise the
//                             read path is combinational.
// -----------------------------------------------------------------------------
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memwrite,
    input  logic                  memread,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] array_rd_data;
    logic [DATA_WIDTH-1:0] gated_rd_data;

    data_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk       (clk),
        .reset_i   (reset),
        .wr_en_i   (memwrite),
        .addr_i    (address),
        .wr_data_i (write_data),
        .rd_data_o (array_rd_data)
    );

    // Gate the load path so no stale word leaks onto the write-back mux.
    assign gated_rd_data = memread ? array_rd_data : '0;

`ifdef DATA_MEMORY_READ_REG_EN
    logic [DATA_WIDTH-1:0] read_d;
    logic [DATA_WIDTH-1:0] read_q;

    assign read_d = gated_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            read_q <= '0;
        end else begin
            read_q <= read_d;
        end
    end

    assign read_data = read_q;
`else
    assign read_data = gated_rd_data;
`endif

endmodule : data_memory

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Self-checking bench for data_memory (default, combinational-read build).
// Stimulus issues one operation per cycle and pushes the hand-computed
// read_data expected for that cycle into a queue; a monitor pops and compares
// on the falling edge, before the next rising edge commits any write.
// -----------------------------------------------------------------------------
module tb_data_memory;
    import data_memory_pkg::*;

    logic     clk;
    logic     reset;
    logic     memwrite;
    logic     memread;
    dm_addr_t address;
    dm_word_t write_data;
    dm_word_t read_data;

    typedef struct {
        string    name;
        dm_word_t value;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    data_memory dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .memread    (memread),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input dm_word_t actual, input dm_word_t expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus. When chk is set, the expected read_data for this
    // cycle (pre-edge contents) is queued for the monitor.
    task automatic step(input logic rst, input logic we, input logic re,
                        input dm_addr_t addr, input dm_word_t wdata,
                        input logic chk, input dm_word_t exp_val, input string name);
        @(posedge clk);
        #1;
        reset      = rst;
        memwrite   = we;
        memread    = re;
        address    = addr;
        write_data = wdata;
        if (chk) exp_q.push_back('{name: name, value: exp_val});
    endtask

    // Monitor: compares whatever the stimulus queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name, read_data, e.value);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        memwrite   = 1'b0;
        memread    = 1'b0;
        address    = '0;
        write_data = '0;

        // Reset state: output 0 whether gated or reading an unwritten word.
        step(1, 0, 1, 10'd100, 32'h0,        1, 32'h0,        "reset_read_100");
        step(1, 0, 0, 10'd100, 32'h0,        1, 32'h0,        "reset_gated");
        step(0, 0, 1, 10'd100, 32'h0,        1, 32'h0,        "unwritten_100");

        // Write then read.
        step(0, 1, 0, 10'd10,  32'hDEADBEEF, 0, 32'h0,        "");
        step(0, 1, 0, 10'd20,  32'hCAFEBABE, 0, 32'h0,        "");
        step(0, 0, 1, 10'd10,  32'h0,        1, 32'hDEADBEEF, "read_10");
        step(0, 0, 1, 10'd20,  32'h0,        1, 32'hCAFEBABE, "read_20");

        // Read gating.
        step(0, 0, 0, 10'd10,  32'h0,        1, 32'h0,        "gated_10");
        step(0, 0, 1, 10'd10,  32'h0,        1, 32'hDEADBEEF, "ungated_10");

        // Simultaneous read/write: old word before the edge, new word after.
        step(0, 1, 1, 10'd20,  32'h0BADF00D, 1, 32'hCAFEBABE, "rw_20_before");
        step(0, 0, 1, 10'd20,  32'h0,        1, 32'h0BADF00D, "rw_20_after");

        // Reset clears everything and drops the write issued in the reset cycle.
        step(0, 1, 0, 10'd0,    32'h12345678, 0, 32'h0,        "");
        step(0, 1, 0, 10'd1023, 32'h12345678, 0, 32'h0,        "");
        step(0, 0, 1, 10'd1023, 32'h0,        1, 32'h12345678, "pre_reset_1023");
        step(1, 1, 1, 10'd5,    32'hAAAA5555, 1, 32'h0,        "reset_cycle_5");
        step(0, 0, 1, 10'd0,    32'h0,        1, 32'h0,        "post_reset_0");
        step(0, 0, 1, 10'd1023, 32'h0,        1, 32'h0,        "post_reset_1023");
        step(0, 0, 1, 10'd5,    32'h0,        1, 32'h0,        "dropped_write_5");
        step(0, 0, 1, 10'd10,   32'h0,        1, 32'h0,        "post_reset_10");
        step(0, 0, 1, 10'd20,   32'h0,        1, 32'h0,        "post_reset_20");

        // Address boundaries: distinct values at 0, 1, 1023; neighbours untouched.
        step(0, 1, 0, 10'd0,    32'h11111111, 0, 32'h0,        "");
        step(0, 1, 0, 10'd1,    32'h22222222, 0, 32'h0,        "");
        step(0, 1, 0, 10'd1023, 32'h33333333, 0, 32'h0,        "");
        step(0, 0, 1, 10'd0,    32'h0,        1, 32'h11111111, "bound_0");
        step(0, 0, 1, 10'd1,    32'h0,        1, 32'h22222222, "bound_1");
        step(0, 0, 1, 10'd1023, 32'h0,        1, 32'h33333333, "bound_1023");
        step(0, 0, 1, 10'd2,    32'h0,        1, 32'h0,        "bound_2");
        step(0, 0, 1, 10'd1022, 32'h0,        1, 32'h0,        "bound_1022");
        step(0, 0, 1, 10'd512,  32'h0,        1, 32'h0,        "bound_512");

        // Writes resume normally after reset; overwrite a boundary word.
        step(0, 1, 1, 10'd1023, 32'hFEEDFACE, 1, 32'h33333333, "overwrite_before");
        step(0, 0, 1, 10'd1023, 32'h0,        1, 32'hFEEDFACE, "overwrite_after");
        step(0, 0, 0, 10'd1023, 32'h0,        1, 32'h0,        "gated_1023");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_memory
